// File: rtl/sed_scan_ctrl_pkg.sv
// Shared definitions for the SEDGA scan controller: FSM state encoding,
// synchroniser depth and the per-state drive pattern toward SEDGA.
package sed_scan_ctrl_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CHECK     = 3'd4
    } state_t;

    typedef struct packed {
        logic enable;
        logic start;
        logic frcerr;
        logic busy;
    } drive_t;

    // Output pattern registered alongside every state change, so the SEDGA
    // controls and BUSY always match the state being entered.
    function automatic drive_t drive_for(state_t s, logic st);
        drive_t d;
        d        = '0;
        d.enable = (s != ST_OFF);
        d.start  = (s == ST_START);
        d.busy   = (s == ST_START) || (s == ST_WAIT_DONE) || (s == ST_CHECK);
        d.frcerr = st && d.busy;
        return d;
    endfunction

endpackage

// File: rtl/sed_scan_ctrl_sync.sv
// Multi-flop synchroniser for the three asynchronous SEDGA status lines.
module sed_scan_ctrl_sync
    import sed_scan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [SYNC_DEPTH-1:0][2:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/sed_scan_ctrl.sv
// Scan controller for SEDGA: single, periodic and forced-error scans with
// timeout supervision, sticky error/timeout flags and a saturating error count.
module sed_scan_ctrl
    import sed_scan_ctrl_pkg::*;
#(
    parameter int SCAN_INTERVAL = 1024,
    parameter int SCAN_TIMEOUT  = 2000000,
    parameter int CHECK_CYCLES  = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 AUTO,
    input  logic                 REQ,
    input  logic                 SELFTEST,
    input  logic                 CLR,
    input  logic                 SEDDONE,
    input  logic                 SEDINPROG,
    input  logic                 SEDERR,
    output logic                 SEDENABLE,
    output logic                 SEDSTART,
    output logic                 SEDFRCERR,
    output logic                 BUSY,
    output logic                 SCAN_OK,
    output logic                 ERR_FLAG,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 TIMEOUT_FLAG,
    output logic                 ST_DONE,
    output logic                 ST_PASS,
    output logic [2:0]           dbg_state
);

    localparam int INT_W = (SCAN_INTERVAL > 0) ? $clog2(SCAN_INTERVAL + 1) : 1;
    localparam int TO_W  = (SCAN_TIMEOUT > 1)  ? $clog2(SCAN_TIMEOUT)      : 1;
    localparam int CHK_W = (CHECK_CYCLES > 1)  ? $clog2(CHECK_CYCLES)      : 1;

    localparam logic [INT_W-1:0] INT_LAST = INT_W'(SCAN_INTERVAL);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SCAN_TIMEOUT - 1);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CHECK_CYCLES - 1);

    state_t             state;
    drive_t             drv;
    logic               st_mode;
    logic               prog_q;
    logic [INT_W-1:0]   int_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [CHK_W-1:0]   chk_cnt;
    logic [2:0]         sed_s;
    logic               done_s;
    logic               prog_s;
    logic               err_s;
    logic               start_scan;

    sed_scan_ctrl_sync u_sync (
        .clk (CLK),
        .rst (RST),
        .d   ({SEDERR, SEDINPROG, SEDDONE}),
        .q   (sed_s)
    );

    assign done_s = sed_s[0];
    assign prog_s = sed_s[1];
    assign err_s  = sed_s[2];

    assign start_scan = SELFTEST || REQ || (AUTO && (int_cnt == INT_LAST));

    assign SEDENABLE = drv.enable;
    assign SEDSTART  = drv.start;
    assign SEDFRCERR = drv.frcerr;
    assign BUSY      = drv.busy;
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_OFF;
            drv          <= '0;
            st_mode      <= 1'b0;
            prog_q       <= 1'b0;
            int_cnt      <= '0;
            to_cnt       <= '0;
            chk_cnt      <= '0;
            SCAN_OK      <= 1'b0;
            ERR_FLAG     <= 1'b0;
            ERR_CNT      <= '0;
            TIMEOUT_FLAG <= 1'b0;
            ST_DONE      <= 1'b0;
            ST_PASS      <= 1'b0;
        end else begin
            SCAN_OK <= 1'b0;
            ST_DONE <= 1'b0;
            prog_q  <= prog_s;

            // Later assignments in this block override the clear, so a flag
            // set in the same cycle as CLR survives.
            if (CLR) begin
                ERR_FLAG     <= 1'b0;
                ERR_CNT      <= '0;
                TIMEOUT_FLAG <= 1'b0;
            end

            if (!EN) begin
                state   <= ST_OFF;
                drv     <= drive_for(ST_OFF, 1'b0);
                st_mode <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state <= ST_IDLE;
                        drv   <= drive_for(ST_IDLE, 1'b0);
                    end

                    ST_IDLE: begin
                        if (start_scan) begin
                            state   <= ST_START;
                            drv     <= drive_for(ST_START, SELFTEST);
                            st_mode <= SELFTEST;
                            int_cnt <= '0;
                            to_cnt  <= '0;
                        end else if (AUTO) begin
                            int_cnt <= int_cnt + 1'b1;
                        end
                    end

                    ST_START, ST_WAIT_DONE: begin
                        if (to_cnt == TO_LAST) begin
                            TIMEOUT_FLAG <= 1'b1;
                            state        <= ST_IDLE;
                            drv          <= drive_for(ST_IDLE, 1'b0);
                            st_mode      <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                            if (state == ST_START && prog_s) begin
                                state <= ST_WAIT_DONE;
                                drv   <= drive_for(ST_WAIT_DONE, st_mode);
                            end else if (state == ST_WAIT_DONE &&
                                         (done_s || (prog_q && !prog_s))) begin
                                state   <= ST_CHECK;
                                drv     <= drive_for(ST_CHECK, st_mode);
                                chk_cnt <= '0;
                            end
                        end
                    end

                    ST_CHECK: begin
                        if (chk_cnt == CHK_LAST) begin
                            state   <= ST_IDLE;
                            drv     <= drive_for(ST_IDLE, 1'b0);
                            st_mode <= 1'b0;
                            if (st_mode) begin
                                ST_DONE <= 1'b1;
                                ST_PASS <= err_s;
                            end else if (err_s) begin
                                ERR_FLAG <= 1'b1;
                                if (CLR) begin
                                    ERR_CNT <= ERR_CNT_W'(1);
                                end else if (!(&ERR_CNT)) begin
                                    ERR_CNT <= ERR_CNT + 1'b1;
                                end
                            end else begin
                                SCAN_OK <= 1'b1;
                            end
                        end else begin
                            chk_cnt <= chk_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state   <= ST_OFF;
                        drv     <= drive_for(ST_OFF, 1'b0);
                        st_mode <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sed_scan_ctrl.sv
// Directed bench for sed_scan_ctrl with a small behavioural SEDGA model and a
// result-pulse scoreboard.
module tb_sed_scan_ctrl;

    localparam int SCAN_INTERVAL = 16;
    localparam int SCAN_TIMEOUT  = 100;
    localparam int CHECK_CYCLES  = 4;
    localparam int ERR_CNT_W     = 2;
    localparam int SCAN_LEN      = 20;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    // Result event codes: {kind[1:0], st_pass}
    localparam logic [2:0] EV_OK      = 3'b010;
    localparam logic [2:0] EV_ST_PASS = 3'b101;
    localparam logic [2:0] EV_ST_FAIL = 3'b100;
    localparam logic [2:0] EV_TIMEOUT = 3'b110;

    logic CLK = 1'b0;
    logic RST, EN, AUTO, REQ, SELFTEST, CLR;
    logic SEDDONE, SEDINPROG, SEDERR;
    logic SEDENABLE, SEDSTART, SEDFRCERR, BUSY, SCAN_OK, ERR_FLAG;
    logic [ERR_CNT_W-1:0] ERR_CNT;
    logic TIMEOUT_FLAG, ST_DONE, ST_PASS;
    logic [2:0] dbg_state;

    logic mute       = 1'b0;
    logic force_err  = 1'b0;
    logic frc_broken = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [2:0] exp_q[$];

    assign SEDERR = (SEDFRCERR && !frc_broken) || force_err;

    sed_scan_ctrl #(
        .SCAN_INTERVAL (SCAN_INTERVAL),
        .SCAN_TIMEOUT  (SCAN_TIMEOUT),
        .CHECK_CYCLES  (CHECK_CYCLES),
        .ERR_CNT_W     (ERR_CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .AUTO         (AUTO),
        .REQ          (REQ),
        .SELFTEST     (SELFTEST),
        .CLR          (CLR),
        .SEDDONE      (SEDDONE),
        .SEDINPROG    (SEDINPROG),
        .SEDERR       (SEDERR),
        .SEDENABLE    (SEDENABLE),
        .SEDSTART     (SEDSTART),
        .SEDFRCERR    (SEDFRCERR),
        .BUSY         (BUSY),
        .SCAN_OK      (SCAN_OK),
        .ERR_FLAG     (ERR_FLAG),
        .ERR_CNT      (ERR_CNT),
        .TIMEOUT_FLAG (TIMEOUT_FLAG),
        .ST_DONE      (ST_DONE),
        .ST_PASS      (ST_PASS),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // ---------------- SEDGA model ----------------
    initial begin
        SEDINPROG = 1'b0;
        SEDDONE   = 1'b0;
        forever begin
            @(negedge CLK);
            if (SEDSTART && !mute) begin
                repeat (2) @(negedge CLK);
                SEDINPROG = 1'b1;
                repeat (SCAN_LEN) @(negedge CLK);
                SEDINPROG = 1'b0;
                SEDDONE   = 1'b1;
                @(negedge CLK);
                SEDDONE   = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic got(input logic [2:0] ev);
        logic [2:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_event: got %b at cycle %0d, nothing expected", ev, cyc);
        end else begin
            want = exp_q.pop_front();
            if (ev !== want) begin
                errors++;
                $display("FAIL result_event: got %b, want %b at cycle %0d", ev, want, cyc);
            end
        end
    endtask

    initial begin
        logic to_prev;
        to_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (SCAN_OK === 1'b1) got(EV_OK);
                if (ST_DONE === 1'b1) got({2'b10, ST_PASS});
                if (TIMEOUT_FLAG === 1'b1 && !to_prev) got(EV_TIMEOUT);
            end
            to_prev = (TIMEOUT_FLAG === 1'b1);
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pulse(input logic r, input logic s);
        REQ      = r;
        SELFTEST = s;
        @(negedge CLK);
        REQ      = 1'b0;
        SELFTEST = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input string name, input int budget);
        int n;
        n = 0;
        while (BUSY !== level && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (BUSY !== level) begin
            errors++;
            $display("FAIL %s: BUSY=%b after %0d cycles, want %b", name, BUSY, n, level);
        end
    endtask

    task automatic wait_sig(input string name, input int sel, input int budget);
        int n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            case (sel)
                0:       hit = (SEDSTART === 1'b1);
                1:       hit = (TIMEOUT_FLAG === 1'b1);
                2:       hit = (dbg_state === S_WAIT);
                default: hit = (dbg_state === S_CHECK);
            endcase
            if (!hit) begin
                @(negedge CLK);
                n++;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: not reached within %0d cycles", name, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1;
        RST = 1'b1; EN = 1'b0; AUTO = 1'b0; REQ = 1'b0; SELFTEST = 1'b0; CLR = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_state",     dbg_state,    S_OFF);
        chk("rst_sedenable", SEDENABLE,    0);
        chk("rst_busy",      BUSY,         0);
        chk("rst_err_cnt",   ERR_CNT,      0);
        chk("rst_flags",     {ERR_FLAG, TIMEOUT_FLAG, ST_PASS}, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("off_hold", SEDENABLE, 0);

        EN = 1'b1;
        @(negedge CLK);
        chk("en_idle_state", dbg_state, S_IDLE);
        chk("en_sedenable",  SEDENABLE, 1);

        // Single clean scan
        exp_q.push_back(EV_OK);
        pulse(1'b1, 1'b0);
        chk("req_sedstart", SEDSTART, 1);
        chk("req_busy",     BUSY,     1);
        wait_busy(1'b0, "req_scan_end", 200);
        @(negedge CLK);
        chk("req_err_flag", ERR_FLAG, 0);

        // Self-test scan
        exp_q.push_back(EV_ST_PASS);
        pulse(1'b0, 1'b1);
        chk("st_frcerr_start", SEDFRCERR, 1);
        wait_sig("st_reach_check", 3, 200);
        chk("st_frcerr_check", SEDFRCERR, 1);
        wait_busy(1'b0, "st_scan_end", 200);
        chk("st_frcerr_idle", SEDFRCERR, 0);
        chk("st_err_cnt",     ERR_CNT,   0);

        // REQ and SELFTEST together: self-test wins
        exp_q.push_back(EV_ST_PASS);
        pulse(1'b1, 1'b1);
        chk("both_frcerr", SEDFRCERR, 1);
        wait_busy(1'b0, "both_scan_end", 200);

        // Self-test where the forced error never shows up
        frc_broken = 1'b1;
        exp_q.push_back(EV_ST_FAIL);
        pulse(1'b0, 1'b1);
        wait_busy(1'b0, "stfail_scan_end", 200);
        frc_broken = 1'b0;
        chk("stfail_err_flag", ERR_FLAG, 0);

        // Errored normal scans with 2-bit saturating counter
        force_err = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pulse(1'b1, 1'b0);
            wait_busy(1'b0, "err_scan_end", 200);
            chk($sformatf("err_cnt_%0d", i), ERR_CNT, (i > 3) ? 3 : i);
            chk("err_flag", ERR_FLAG, 1);
        end
        force_err = 1'b0;

        // EN dropped mid WAIT_DONE: scan dropped, sticky state kept
        pulse(1'b1, 1'b0);
        wait_sig("en_drop_reach_wait", 2, 100);
        EN = 1'b0;
        @(negedge CLK);
        chk("endrop_sedenable", SEDENABLE, 0);
        chk("endrop_busy",      BUSY,      0);
        chk("endrop_state",     dbg_state, S_OFF);
        chk("endrop_err_cnt",   ERR_CNT,   3);
        repeat (40) @(negedge CLK);
        EN = 1'b1;
        repeat (2) @(negedge CLK);

        // CLR held across an errored scan: set wins, count restarts at 1
        force_err = 1'b1;
        CLR = 1'b1;
        pulse(1'b1, 1'b0);
        wait_busy(1'b0, "clrset_scan_end", 200);
        chk("clrset_err_cnt",  ERR_CNT,  1);
        chk("clrset_err_flag", ERR_FLAG, 1);
        CLR = 1'b0;
        force_err = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_err_cnt",  ERR_CNT,  0);
        chk("clr_err_flag", ERR_FLAG, 0);

        // Timeout: SEDGA never answers
        mute = 1'b1;
        exp_q.push_back(EV_TIMEOUT);
        pulse(1'b1, 1'b0);
        chk("to_sedstart", SEDSTART, 1);
        c0 = cyc;
        wait_sig("to_flag", 1, 300);
        c1 = cyc;
        chk("to_latency", c1 - c0, SCAN_TIMEOUT);
        chk("to_sedstart_off", SEDSTART, 0);
        chk("to_state_idle",   dbg_state, S_IDLE);
        chk("to_busy",         BUSY, 0);
        mute = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("to_clr", TIMEOUT_FLAG, 0);

        // Periodic scans: IDLE dwell of SCAN_INTERVAL counted cycles plus the
        // deciding cycle (count 0..SCAN_INTERVAL)
        exp_q.push_back(EV_OK);
        exp_q.push_back(EV_OK);
        AUTO = 1'b1;
        wait_busy(1'b1, "auto_first_start", 60);
        wait_busy(1'b0, "auto_first_end", 200);
        c0 = cyc;
        wait_sig("auto_second_start", 0, 60);
        c1 = cyc;
        AUTO = 1'b0;
        chk("auto_gap", c1 - c0, SCAN_INTERVAL + 1);
        wait_busy(1'b0, "auto_second_end", 200);

        repeat (10) @(negedge CLK);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: bench timed out at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
